zero_count_arbiter: RTL and testbench

- Shares one bit-serial zero-counting engine between NUM_REQ requesters.
- Each requester presents a DATA_W-bit word with a request.
- The block grants one requester at a time in round-robin order, counts the zero bits of that word one bit per cycle, then returns the count tagged with the requester index.
- It sits between byte-producing clients and the shared counting resource, so the per-requester combinational counters are no longer needed.

---
 rtl/zero_count_arbiter.sv | 144 ++++++++++++++
 tb/tb_zero_count_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_count_arbiter.sv
// Round-robin arbiter in front of one shared bit-serial zero counter.
// Each granted word is scanned LSB-first, one bit per cycle, then reported with its requester index.
module zero_count_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned DATA_W  = 8,
    localparam int unsigned CNT_W   = $clog2(DATA_W + 1),
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   din,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        busy,
    output logic [NUM_REQ-1:0]          done,
    output logic [CNT_W-1:0]            count,
    output logic [ID_W-1:0]             count_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0]     bit_q, bit_d;
    logic [CNT_W-1:0]     acc_q, acc_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ID_W-1:0]      count_id_q, count_id_d;

    logic [DATA_W-1:0]    words [NUM_REQ];
    logic                 win_found;
    logic [ID_W-1:0]      win_idx;
    int unsigned          cand;

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign words[g] = din[g*DATA_W +: DATA_W];
    end

    // Round-robin search starting at ptr_q, wrapping past NUM_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req[ID_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(cand);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        acc_d      = acc_q;
        id_d       = id_q;
        gnt_d      = '0;
        done_d     = '0;
        count_d    = count_q;
        count_id_d = count_id_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    shift_d = words[win_idx];
                    id_d    = win_idx;
                    acc_d   = '0;
                    bit_d   = '0;
                    ptr_d   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
                    state_d = COUNT;
                end
            end
            COUNT: begin
                acc_d   = acc_q + CNT_W'(~shift_q[0]);
                shift_d = shift_q >> 1;
                bit_d   = bit_q + CNT_W'(1);
                if (bit_q == CNT_W'(DATA_W - 1)) begin
                    count_d    = acc_d;
                    count_id_d = id_q;
                    done_d     = NUM_REQ'(1) << id_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            shift_q    <= '0;
            bit_q      <= '0;
            acc_q      <= '0;
            id_q       <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            count_q    <= '0;
            count_id_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            acc_q      <= acc_d;
            id_q       <= id_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
            count_id_q <= count_id_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign count    = count_q;
    assign count_id = count_id_q;

endmodule

// File: tb/tb_zero_count_arbiter.sv
// Bench for zero_count_arbiter: directed vectors, multi-cycle corner sequences and
// random traffic compared every cycle against a transaction-timeline model.
module tb_zero_count_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = $clog2(DW + 1);
    localparam int unsigned IW = $clog2(NR);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  din;
    logic [NR-1:0]     gnt;
    logic              busy;
    logic [NR-1:0]     done;
    logic [CW-1:0]     count;
    logic [IW-1:0]     count_id;

    int n_checks;
    int n_errors;
    int cyc = 0;
    bit chk_en = 1'b0;

    zero_count_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .din      (din),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .count_id (count_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: an operation occupies DATA_W+2 cycles from its grant; done lands DATA_W cycles after it.
    typedef struct {
        int          ptr;
        int          remain;
        int          pend_cnt;
        int          pend_id;
        int          cnt;
        int          id;
        logic [NR-1:0] gnt;
        logic [NR-1:0] done;
        logic        busy;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.ptr = 0; r.remain = 0; r.pend_cnt = 0; r.pend_id = 0;
        r.cnt = 0; r.id = 0; r.gnt = '0; r.done = '0; r.busy = 1'b0;
        return r;
    endfunction

    function automatic model_t model_next(model_t c, logic [NR-1:0] r, logic [NR*DW-1:0] d);
        model_t n;
        int     k;
        bit     found;
        logic [DW-1:0] w;
        n = c;
        n.gnt = '0;
        n.done = '0;
        found = 1'b0;
        k = 0;
        if (c.remain == 0) begin
            for (int i = 0; i < int'(NR); i++) begin
                if (!found && r[(c.ptr + i) % NR]) begin
                    found = 1'b1;
                    k = (c.ptr + i) % NR;
                end
            end
            if (found) begin
                w = d[k*DW +: DW];
                n.gnt = NR'(1) << k;
                n.pend_cnt = DW - $countones(w);
                n.pend_id = k;
                n.ptr = (k + 1) % NR;
                n.remain = DW + 1;
            end
        end else begin
            n.remain = c.remain - 1;
            if (n.remain == 1) begin
                n.done = NR'(1) << c.pend_id;
                n.cnt = c.pend_cnt;
                n.id = c.pend_id;
            end
        end
        n.busy = (n.remain != 0);
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, req, din);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_gnt",   32'(gnt),      32'(m.gnt));
            check("mdl_done",  32'(done),     32'(m.done));
            check("mdl_busy",  32'(busy),     32'(m.busy));
            check("mdl_count", 32'(count),    32'(m.cnt));
            check("mdl_id",    32'(count_id), 32'(m.id));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_gnt(input int limit, output int idx);
        idx = -1;
        for (int t = 0; t < limit && idx < 0; t++) begin
            tick();
            for (int k = 0; k < int'(NR); k++) begin
                if (gnt[k]) idx = k;
            end
        end
        if (idx < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL gnt_timeout: got none expected grant within %0d cycles", limit);
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 20 && busy; t++) tick();
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_single(input int rq, input logic [DW-1:0] word, input int exp_cnt);
        int idx;
        int bcnt;
        int early;
        wait_idle();
        din = $urandom;
        din[rq*DW +: DW] = word;
        req = NR'(1) << rq;
        wait_gnt(3, idx);
        check("vec_gnt_idx", 32'(idx), 32'(rq));
        check("vec_gnt_hot", 32'(gnt), 32'(1) << rq);
        req = '0;
        din = $urandom;
        bcnt = busy ? 1 : 0;
        early = 0;
        for (int t = 1; t < int'(DW); t++) begin
            tick();
            if (busy) bcnt++;
            if (done != 0 || gnt != 0) early++;
        end
        check("vec_early_done", 32'(early), 32'd0);
        tick();
        if (busy) bcnt++;
        check("vec_done",  32'(done),     32'(1) << rq);
        check("vec_count", 32'(count),    32'(exp_cnt));
        check("vec_id",    32'(count_id), 32'(rq));
        tick();
        check("vec_busy_len", 32'(bcnt), 32'(DW + 1));
        check("vec_after", {27'd0, busy, done}, 32'd0);
        check("vec_hold_count", 32'(count), 32'(exp_cnt));
    endtask

    typedef struct {
        int          rq;
        logic [DW-1:0] word;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int idx;
        int last;
        int seen;
        int rr_cnt [4];
        n_checks = 0;
        n_errors = 0;
        req = '0;
        din = '0;

        vecs[0] = '{0, 8'hA5, 4};
        vecs[1] = '{2, 8'h00, 8};
        vecs[2] = '{2, 8'hFF, 0};
        vecs[3] = '{1, 8'h3C, 4};
        vecs[4] = '{3, 8'h80, 7};
        vecs[5] = '{0, 8'h01, 7};
        vecs[6] = '{3, 8'h55, 4};
        vecs[7] = '{1, 8'h0F, 4};
        rr_cnt = '{1, 7, 4, 4};

        repeat (3) tick();
        chk_en = 1'b1;
        rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            check("reset_idle", {gnt, done, 3'd0, busy, count, 2'd0, count_id}, 32'd0);
        end

        for (int v = 0; v < 8; v++) run_single(vecs[v].rq, vecs[v].word, vecs[v].exp_cnt);

        // All requesters held high: strict RR order from ptr=0, one grant every DW+2 cycles.
        do_reset();
        din = 32'hF00F01FE;
        req = 4'b1111;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(12, idx);
            check("rr_gnt", 32'(idx), 32'(g % 4));
            if (g > 0) check("rr_gap", 32'(cyc - last), 32'(DW + 2));
            last = cyc;
            repeat (DW) tick();
            check("rr_done",  32'(done),  32'(1) << (g % 4));
            check("rr_count", 32'(count), 32'(rr_cnt[g % 4]));
        end
        req = '0;
        wait_idle();

        // In-flight word is immune to din/req changes after the grant.
        do_reset();
        din = $urandom;
        din[15:8] = 8'h3C;
        req = 4'b0010;
        wait_gnt(3, idx);
        check("mid_gnt", 32'(idx), 32'd1);
        din[15:8] = 8'h00;
        req = '0;
        repeat (DW) tick();
        check("mid_done",  32'(done),     32'b0010);
        check("mid_count", 32'(count),    32'd4);
        check("mid_id",    32'(count_id), 32'd1);
        wait_idle();

        // Reset three cycles into COUNT discards the operation and restores ptr=0.
        do_reset();
        din = 32'h12345678;
        req = 4'b0100;
        wait_gnt(3, idx);
        check("rst_gnt", 32'(idx), 32'd2);
        req = '0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {gnt, done, 3'd0, busy, count, 2'd0, count_id}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int t = 0; t < int'(DW) + 4; t++) begin
            tick();
            if (done != 0 || busy) seen++;
        end
        check("rst_no_done", 32'(seen), 32'd0);
        req = 4'b1111;
        wait_gnt(3, idx);
        check("rst_ptr0", 32'(idx), 32'd0);
        req = '0;
        wait_idle();

        for (int t = 0; t < 1500; t++) begin
            req = NR'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = '0;
            din = $urandom;
            tick();
        end
        req = '0;
        repeat (DW + 4) tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
